mmio_demux: RTL

MMIO_DEMUX -- requirements
Module: mmio_demux

---
 rtl/mmio_pkg.sv | 8 +
 rtl/mmio_decode.sv | 20 ++
 rtl/mmio_demux.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared response codes, FSM states and default slave map for the MMIO demux
package mmio_pkg;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] DECERR = 2'b11;
  localparam int NSLV_DEF = 3;
  localparam logic [2:0][15:0] SLV_BASE_DEF = {16'h0C00, 16'h1000, 16'h0200};
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
endpackage

// File: rtl/mmio_decode.sv
// mmio_decode: maps address bits [31:16] onto the lowest matching slave index
module mmio_decode import mmio_pkg::*; #(
  parameter int NSLV = NSLV_DEF,
  parameter logic [NSLV-1:0][15:0] SLV_BASE = SLV_BASE_DEF,
  localparam int IW = NSLV > 1 ? $clog2(NSLV) : 1
) (
  input  logic [15:0]   addr_hi,
  output logic          hit,
  output logic [IW-1:0] idx
);
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NSLV - 1; i >= 0; i--)
      if (addr_hi == SLV_BASE[i]) begin
        hit = 1'b1;
        idx = IW'(i);
      end
  end
endmodule

// File: rtl/mmio_demux.sv
// mmio_demux: routes one AXI-lite slave port onto NSLV AXI-lite MMIO masters,
// with independent read and write FSMs and fully registered outputs.
module mmio_demux import mmio_pkg::*; #(
  parameter int NSLV = NSLV_DEF,
  parameter logic [NSLV-1:0][15:0] SLV_BASE = SLV_BASE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        s_axi_awaddr,
  input  logic               s_axi_awvalid,
  output logic               s_axi_awready,
  input  logic [63:0]        s_axi_wdata,
  input  logic               s_axi_wvalid,
  output logic               s_axi_wready,
  output logic [1:0]         s_axi_bresp,
  output logic               s_axi_bvalid,
  input  logic               s_axi_bready,
  input  logic [31:0]        s_axi_araddr,
  input  logic               s_axi_arvalid,
  output logic               s_axi_arready,
  output logic [63:0]        s_axi_rdata,
  output logic [1:0]         s_axi_rresp,
  output logic               s_axi_rvalid,
  input  logic               s_axi_rready,
  output logic [15:0]        m_axi_awaddr [NSLV],
  output logic [NSLV-1:0]    m_axi_awvalid,
  input  logic [NSLV-1:0]    m_axi_awready,
  output logic [63:0]        m_axi_wdata [NSLV],
  output logic [NSLV-1:0]    m_axi_wvalid,
  input  logic [NSLV-1:0]    m_axi_wready,
  input  logic [1:0]         m_axi_bresp [NSLV],
  input  logic [NSLV-1:0]    m_axi_bvalid,
  output logic [NSLV-1:0]    m_axi_bready,
  output logic [15:0]        m_axi_araddr [NSLV],
  output logic [NSLV-1:0]    m_axi_arvalid,
  input  logic [NSLV-1:0]    m_axi_arready,
  input  logic [63:0]        m_axi_rdata [NSLV],
  input  logic [1:0]         m_axi_rresp [NSLV],
  input  logic [NSLV-1:0]    m_axi_rvalid,
  output logic [NSLV-1:0]    m_axi_rready
);
  localparam int IW = NSLV > 1 ? $clog2(NSLV) : 1;
  state_t rs, rs_n, ws, ws_n;
  logic rd_hit, wr_hit, whit, aw_got, w_got, aw_got_n, w_got_n;
  logic ar_hs, aw_hs, w_hs, m_aw_hs, m_w_hs;
  logic [IW-1:0] rd_idx, wr_idx, ridx, ridx_n, widx, widx_n;
  logic [15:0] araddr_q, awaddr_q;
  logic [63:0] wdata_q;

  mmio_decode #(.NSLV(NSLV), .SLV_BASE(SLV_BASE)) u_rd_dec (.addr_hi(s_axi_araddr[31:16]), .hit(rd_hit), .idx(rd_idx));
  mmio_decode #(.NSLV(NSLV), .SLV_BASE(SLV_BASE)) u_wr_dec (.addr_hi(s_axi_awaddr[31:16]), .hit(wr_hit), .idx(wr_idx));

  // Address and data are broadcast; only the selected slave ever sees a valid.
  for (genvar g = 0; g < NSLV; g++) begin : g_bcast
    assign m_axi_araddr[g] = araddr_q;
    assign m_axi_awaddr[g] = awaddr_q;
    assign m_axi_wdata[g] = wdata_q;
  end

  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs = s_axi_wvalid && s_axi_wready;
  assign m_aw_hs = m_axi_awvalid[widx] && m_axi_awready[widx];
  assign m_w_hs = m_axi_wvalid[widx] && m_axi_wready[widx];
  assign ridx_n = ar_hs ? rd_idx : ridx;
  assign widx_n = aw_hs ? wr_idx : widx;

  always_comb begin
    rs_n = rs;
    case (rs)
      IDLE: if (ar_hs) rs_n = rd_hit ? ADDR : RESP;
      ADDR: if (m_axi_arready[ridx]) rs_n = DATA;
      DATA: if (m_axi_rvalid[ridx]) rs_n = RESP;
      default: if (s_axi_rready) rs_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rs <= IDLE;
      ridx <= '0;
      araddr_q <= '0;
      s_axi_arready <= 1'b1;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata <= '0;
      s_axi_rresp <= OKAY;
      m_axi_arvalid <= '0;
      m_axi_rready <= '0;
    end else begin
      rs <= rs_n;
      ridx <= ridx_n;
      if (ar_hs) araddr_q <= s_axi_araddr[15:0];
      if (rs == IDLE && rs_n == RESP) begin
        s_axi_rdata <= '0;
        s_axi_rresp <= DECERR;
      end
      if (rs == DATA && rs_n == RESP) begin
        s_axi_rdata <= m_axi_rdata[ridx];
        s_axi_rresp <= m_axi_rresp[ridx];
      end
      s_axi_arready <= rs_n == IDLE;
      s_axi_rvalid <= rs_n == RESP;
      for (int i = 0; i < NSLV; i++) begin
        m_axi_arvalid[i] <= rs_n == ADDR && ridx_n == IW'(i);
        m_axi_rready[i] <= rs_n == DATA && ridx_n == IW'(i);
      end
    end
  end

  // aw_got/w_got mean "captured upstream" in IDLE and "accepted downstream" in ADDR.
  always_comb begin
    ws_n = ws;
    case (ws)
      IDLE: if ((aw_got || aw_hs) && (w_got || w_hs)) ws_n = (aw_hs ? wr_hit : whit) ? ADDR : RESP;
      ADDR: if ((aw_got || m_aw_hs) && (w_got || m_w_hs)) ws_n = DATA;
      DATA: if (m_axi_bvalid[widx]) ws_n = RESP;
      default: if (s_axi_bready) ws_n = IDLE;
    endcase
    aw_got_n = ws_n == ws && (aw_got || (ws == IDLE ? aw_hs : m_aw_hs));
    w_got_n = ws_n == ws && (w_got || (ws == IDLE ? w_hs : m_w_hs));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ws <= IDLE;
      aw_got <= 1'b0;
      w_got <= 1'b0;
      whit <= 1'b0;
      widx <= '0;
      awaddr_q <= '0;
      wdata_q <= '0;
      s_axi_awready <= 1'b1;
      s_axi_wready <= 1'b1;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp <= OKAY;
      m_axi_awvalid <= '0;
      m_axi_wvalid <= '0;
      m_axi_bready <= '0;
    end else begin
      ws <= ws_n;
      aw_got <= aw_got_n;
      w_got <= w_got_n;
      widx <= widx_n;
      if (aw_hs) begin
        whit <= wr_hit;
        awaddr_q <= s_axi_awaddr[15:0];
      end
      if (w_hs) wdata_q <= s_axi_wdata;
      if (ws == IDLE && ws_n == RESP) s_axi_bresp <= DECERR;
      if (ws == DATA && ws_n == RESP) s_axi_bresp <= m_axi_bresp[widx];
      s_axi_awready <= ws_n == IDLE && !aw_got_n;
      s_axi_wready <= ws_n == IDLE && !w_got_n;
      s_axi_bvalid <= ws_n == RESP;
      for (int i = 0; i < NSLV; i++) begin
        m_axi_awvalid[i] <= ws_n == ADDR && widx_n == IW'(i) && !aw_got_n;
        m_axi_wvalid[i] <= ws_n == ADDR && widx_n == IW'(i) && !w_got_n;
        m_axi_bready[i] <= ws_n == DATA && widx_n == IW'(i);
      end
    end
  end
endmodule
